// File: rtl/tc_pkg.sv
// Shared types and default widths for the tensor-core address sequencer.
package tc_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DIM_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/range_cnt.sv
// Loadable counter that returns to base after reaching last; term flags the last value.
// Latency 1 from load/en to cnt; no backpressure (caller gates en).
module range_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] cnt,
  output logic             term
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = term ? base : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == last);

endmodule

// File: rtl/mm_addr_sched.sv
// Generates A/B operand read addresses for one matrix-vector pass (A linear, B re-read per row).
// First beat 1 cycle after start; halt freezes the walk with no beat issued.
module mm_addr_sched
  import tc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [DIM_WIDTH-1:0]  dim_m,
  input  logic [DIM_WIDTH-1:0]  dim_k,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  addr_valid,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
  logic [DIM_WIDTH-1:0]  m_q, m_d;
  logic [DIM_WIDTH-1:0]  k_q, k_d;
  logic                  skip_q, skip_d;

  logic                  accept;
  logic                  degenerate;
  logic                  beat;
  logic [DIM_WIDTH-1:0]  col_cnt, row_cnt;
  logic                  col_term, row_term;

  assign accept     = (state_q == IDLE) && start;
  assign degenerate = (dim_m == '0) || (dim_k == '0);
  assign beat       = (state_q == RUN) && !halt;

  range_cnt #(.WIDTH(DIM_WIDTH)) u_col_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (beat),
    .load_val ('0),
    .base     ('0),
    .last     (k_q - DIM_WIDTH'(1)),
    .cnt      (col_cnt),
    .term     (col_term)
  );

  range_cnt #(.WIDTH(DIM_WIDTH)) u_row_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (beat && col_term),
    .load_val ('0),
    .base     ('0),
    .last     (m_q - DIM_WIDTH'(1)),
    .cnt      (row_cnt),
    .term     (row_term)
  );

  // A zero dimension spends one extra FIN cycle (skip) so done lands 2 cycles after start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = degenerate ? FIN : RUN;
      RUN:     if (beat && col_term && row_term) state_d = FIN;
      FIN:     if (!skip_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    b_base_d = b_base_q;
    m_d      = m_q;
    k_d      = k_q;
    skip_d   = skip_q;
    if (accept) begin
      a_addr_d = a_base;
      b_addr_d = b_base;
      b_base_d = b_base;
      m_d      = dim_m;
      k_d      = dim_k;
      skip_d   = degenerate;
    end else if (beat) begin
      a_addr_d = a_addr_q + ADDR_WIDTH'(1);
      b_addr_d = col_term ? b_base_q : b_addr_q + ADDR_WIDTH'(1);
    end else if (state_q == FIN) begin
      skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_addr_q <= '0;
      b_addr_q <= '0;
      b_base_q <= '0;
      m_q      <= '0;
      k_q      <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      b_base_q <= b_base_d;
      m_q      <= m_d;
      k_q      <= k_d;
      skip_q   <= skip_d;
    end
  end

  always_comb begin
    a_addr     = a_addr_q;
    b_addr     = b_addr_q;
    addr_valid = beat;
    row_last   = beat && col_term;
    busy       = (state_q == RUN);
    done       = (state_q == FIN) && !skip_q;
  end

endmodule

// File: tb/tb_mm_addr_sched.sv
// Randomized bench for mm_addr_sched; expected beats come from a flat index model
// (beat i -> a_base+i, b_base+i%K, row end when i%K==K-1).
module tb_mm_addr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_base, b_base, dim_m, dim_k;
  logic       halt;
  logic [3:0] a_addr, b_addr;
  logic       addr_valid, row_last, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_addr_sched #(.ADDR_WIDTH(4), .DIM_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_base     (a_base),
    .b_base     (b_base),
    .dim_m      (dim_m),
    .dim_k      (dim_k),
    .halt       (halt),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .addr_valid (addr_valid),
    .row_last   (row_last),
    .busy       (busy),
    .done       (done)
  );

  // hmode: 0 = never halt, 1 = random halts, 2 = halt in cycles 2..3 after start.
  // restart: fire extra starts (different bases) during RUN and during FIN.
  task automatic run_pass(input logic [3:0] ab, input logic [3:0] bb,
                          input logic [3:0] dm, input logic [3:0] dk,
                          input int hmode, input bit restart, input string name);
    int total;
    int idx;
    int cyc;
    logic h;
    logic [3:0] ea, eb;
    logic [11:0] got, exp;
    total = int'(dm) * int'(dk);
    idx = 0;
    cyc = 1;
    @(posedge clk); #1;
    start = 1'b1; a_base = ab; b_base = bb; dim_m = dm; dim_k = dk;
    @(posedge clk); #1;
    start = 1'b0;
    a_base = 4'($urandom); b_base = 4'($urandom);
    dim_m = 4'($urandom); dim_k = 4'($urandom);
    if (total == 0) begin
      halt = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({addr_valid, row_last, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL %s degen_cyc1 flags got=%b want=0000", name,
                 {addr_valid, row_last, busy, done});
      end
      @(posedge clk); #1;
      if (restart) start = 1'b1;
    end else begin
      while (idx < total && cyc < 3000) begin
        case (hmode)
          1:       h = ($urandom_range(99) < 30);
          2:       h = (cyc == 2 || cyc == 3);
          default: h = 1'b0;
        endcase
        halt = h;
        if (restart && cyc == 2) begin
          start = 1'b1; a_base = ~ab; b_base = ~bb; dim_m = 4'd1; dim_k = 4'd1;
        end
        @(negedge clk);
        ea  = ab + 4'(idx);
        eb  = bb + 4'(idx % int'(dk));
        exp = {!h, !h && (idx % int'(dk) == int'(dk) - 1), 1'b1, 1'b0, ea, eb};
        got = {addr_valid, row_last, busy, done, a_addr, b_addr};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s beat%0d cyc%0d {vld,rl,busy,done,a,b} got=%h want=%h",
                   name, idx, cyc, got, exp);
        end
        if (!h) idx++;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
      checks++;
      if (idx < total) begin
        errors++;
        $display("FAIL %s timeout beats got=%0d want=%0d", name, idx, total);
      end
      halt = 1'($urandom);
      if (restart) start = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({addr_valid, row_last, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL %s done_cycle flags got=%b want=0001", name,
               {addr_valid, row_last, busy, done});
    end
    @(posedge clk); #1;
    start = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    checks++;
    if ({addr_valid, row_last, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL %s after_done flags got=%b want=0000", name,
               {addr_valid, row_last, busy, done});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0;
    a_base = 4'd0; b_base = 4'd0; dim_m = 4'd0; dim_k = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr_valid, row_last, busy, done, a_addr, b_addr} !== 12'h000) begin
      errors++;
      $display("FAIL reset outputs got=%h want=000",
               {addr_valid, row_last, busy, done, a_addr, b_addr});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle flags got=%b want=000", {addr_valid, busy, done});
    end
  endtask

  task automatic test_basic();
    run_pass(4'd2, 4'd8, 4'd2, 4'd3, 0, 1'b0, "basic");
  endtask

  task automatic test_halt();
    run_pass(4'd2, 4'd8, 4'd2, 4'd3, 2, 1'b0, "halt");
  endtask

  task automatic test_wrap();
    run_pass(4'd14, 4'd15, 4'd1, 4'd3, 0, 1'b0, "wrap");
  endtask

  task automatic test_degenerate();
    run_pass(4'd5, 4'd6, 4'd0, 4'd5, 1, 1'b0, "degen_m0");
    run_pass(4'd5, 4'd6, 4'd3, 4'd0, 1, 1'b1, "degen_k0");
  endtask

  task automatic test_start_while_busy();
    run_pass(4'd3, 4'd4, 4'd2, 4'd4, 0, 1'b1, "restart");
    run_pass(4'd9, 4'd1, 4'd3, 4'd2, 1, 1'b1, "restart_halt");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; a_base = 4'd2; b_base = 4'd8; dim_m = 4'd2; dim_k = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({addr_valid, a_addr, b_addr} !== 9'h14a) begin
      errors++;
      $display("FAIL rst_mid third_beat got=%h want=14a", {addr_valid, a_addr, b_addr});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addr_valid, row_last, busy, done, a_addr, b_addr} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid immediate got=%h want=000",
               {addr_valid, row_last, busy, done, a_addr, b_addr});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({addr_valid, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid no_done cyc%0d got=%b want=000", i, {addr_valid, busy, done});
      end
    end
    run_pass(4'd7, 4'd0, 4'd2, 4'd2, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_pass(4'($urandom), 4'($urandom), 4'($urandom_range(6)),
               4'($urandom_range(6)), 1, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_wrap();
    test_degenerate();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
